// File: rtl/key_event_fifo.sv
// Keyboard event FIFO with auto-repeat: key strobes and repeat events are queued
// for a consumer behind a valid/ready handshake with a registered head entry.
module key_event_fifo #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 2500000
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     key_new,
  input  logic [WIDTH-1:0]         key_code,
  input  logic                     key_held,
  input  logic                     repeat_en,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CW-1:0] DelayLoad = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RateLoad  = CW'(REPEAT_RATE - 1);
  localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] last_code_q;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             overflow_q, overflow_d;

  logic             rpt_push;
  logic             push_req, push_acc, pop, full, drop;
  logic [WIDTH-1:0] push_data;

  // A fresh key strobe always pre-empts the repeat timer, so no repeat fires with key_new.
  assign rpt_push = !key_new && (state_q != StIdle) && key_held && repeat_en && (cnt_q == '0);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_code_q <= '0;
    end else if (key_new) begin
      state_q     <= StDelay;
      cnt_q       <= DelayLoad;
      last_code_q <= key_code;
    end else if (state_q != StIdle) begin
      if (!key_held || !repeat_en) begin
        state_q <= StIdle;
      end else if (cnt_q == '0) begin
        state_q <= StRepeat;
        cnt_q   <= RateLoad;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign push_req    = key_new | rpt_push;
  assign push_data   = key_new ? key_code : last_code_q;
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & out_ready;
  assign full        = (count_q == CountFull);
  assign push_acc    = push_req & (!full | pop);
  assign drop        = push_req & full & !pop;
  assign rd_ptr_next = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d   = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_next : rd_ptr_q;
    overflow_d = drop | (overflow_q & !clr_overflow);

    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // With one entry left, the next head is the word being written this cycle (not yet in mem).
    out_data_d = out_data_q;
    if (pop) begin
      if (count_q == CountOne) begin
        out_data_d = push_acc ? push_data : out_data_q;
      end else begin
        out_data_d = mem_q[rd_ptr_next];
      end
    end else if ((count_q == '0) && push_acc) begin
      out_data_d = push_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data = out_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Scoreboard bench for key_event_fifo: stimulus queues expected head words (with the
// cycle they must appear, or -1), a monitor pops and compares on every handshake.
module tb_key_event_fifo;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RR = 3;

  logic         sys_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_new = 1'b0;
  logic [W-1:0] key_code = '0;
  logic         key_held = 1'b0;
  logic         repeat_en = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic [2:0]   count;
  logic         overflow;
  logic         clr_overflow = 1'b0;

  key_event_fifo #(
    .WIDTH(W), .DEPTH(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .key_new(key_new), .key_code(key_code),
    .key_held(key_held), .repeat_en(repeat_en), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int           at;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic sb_push(input logic [W-1:0] d, input int at);
    exp_t e;
    e.data = d;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [W-1:0] code);
    key_new  = 1'b1;
    key_code = code;
    tick(1);
    key_new  = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: got %0h at cycle %0d, expected no output", out_data, cyc);
        end else begin
          e = sb.pop_front();
          check("pop_data", 32'(out_data), 32'(e.data));
          if (e.at >= 0) check("pop_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  initial begin : stim
    int c;
    int d;
    int s;

    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Single key, consumer ready
    out_ready = 1'b1;
    c = cyc;
    sb_push(8'h41, c + 1);
    strobe(8'h41);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h41);
    tick(1);
    check("single_valid_drop", 32'(out_valid), 32'd0);
    check("single_count", 32'(count), 32'd0);

    // Fill past capacity
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb_push(W'(i), -1);
      strobe(W'(i));
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_head", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("overflow_clr", 32'(overflow), 32'd0);

    // Drop with clear in the same cycle, then push+pop at full across the wrap
    for (int i = 0; i < 4; i++) begin
      sb_push(W'(8'h11 + i), -1);
      strobe(W'(8'h11 + i));
    end
    clr_overflow = 1'b1;
    strobe(8'h15);
    clr_overflow = 1'b0;
    check("set_wins_overflow", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd4);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("overflow_clr2", 32'(overflow), 32'd0);
    sb_push(8'h16, -1);
    out_ready = 1'b1;
    strobe(8'h16);
    out_ready = 1'b0;
    check("pushpop_count", 32'(count), 32'd4);
    check("pushpop_overflow", 32'(overflow), 32'd0);
    check("pushpop_head", 32'(out_data), 32'h12);
    out_ready = 1'b1;
    tick(4);
    check("wrap_drain_count", 32'(count), 32'd0);

    // Auto-repeat: pushes at strobe+8, +11, +14, +17, +20
    key_held  = 1'b1;
    repeat_en = 1'b1;
    c = cyc;
    sb_push(8'h61, c + 1);
    for (int k = 0; k < 5; k++) sb_push(8'h61, c + 9 + 3 * k);
    strobe(8'h61);
    tick(20);
    key_held = 1'b0;
    tick(10);
    check("repeat_all_seen", 32'(sb.size()), 32'd0);
    check("repeat_idle_count", 32'(count), 32'd0);

    // New key while repeating restarts the full delay with the new code
    key_held = 1'b1;
    c = cyc;
    sb_push(8'h61, c + 1);
    sb_push(8'h61, c + 9);
    strobe(8'h61);
    tick(9);
    d = cyc;
    sb_push(8'h62, d + 1);
    sb_push(8'h62, d + 9);
    strobe(8'h62);
    tick(9);
    key_held = 1'b0;
    tick(6);
    check("newkey_all_seen", 32'(sb.size()), 32'd0);

    // repeat_en low: only the strobe itself is queued
    key_held  = 1'b1;
    repeat_en = 1'b0;
    c = cyc;
    sb_push(8'h63, c + 1);
    strobe(8'h63);
    tick(14);
    check("no_repeat_disabled", 32'(sb.size()), 32'd0);

    // Reset mid-operation with count=3, overflow set, FSM in REPEAT
    repeat_en = 1'b1;
    out_ready = 1'b0;
    sb_push(8'h71, -1);
    sb_push(8'h72, -1);
    for (int i = 0; i < 4; i++) strobe(W'(8'h71 + i));
    s = cyc;
    strobe(8'h75);
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;
    tick(s + 9 - cyc);
    check("pre_reset_count", 32'(count), 32'd3);
    check("pre_reset_overflow", 32'(overflow), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    sb.delete();
    tick(2);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick(15);
    check("no_repeat_after_reset", 32'(count), 32'd0);
    key_held = 1'b0;
    c = cyc;
    sb_push(8'h5a, c + 1);
    strobe(8'h5a);
    tick(2);
    check("post_reset_count", 32'(count), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
